// File: rtl/seq_divide_pkg.sv
// Shared types and default widths for the sequential unsigned divider.
// The optional div_zero result flag is enabled by SEQ_DIVIDE_DZ_FLAG_EN.
package seq_divide_pkg;

    localparam int unsigned DIV_DW_N  = 17;
    localparam int unsigned DIV_DW_D  = 9;
    localparam int unsigned DIV_CNT_W = $clog2(DIV_DW_N + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } div_state_t;

    // Step-counter width able to hold the value n (one count per quotient bit)
    function automatic int unsigned div_cnt_w(input int unsigned n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_divide_if.sv
// Operand and result handshakes of seq_divide.
// div_zero is present only when SEQ_DIVIDE_DZ_FLAG_EN is defined.
interface seq_divide_if
    import seq_divide_pkg::*;
#(
    parameter int unsigned DW_N = DIV_DW_N,
    parameter int unsigned DW_D = DIV_DW_D
) ();

    logic            in_valid;
    logic            in_ready;
    logic [DW_N-1:0] dividend;
    logic [DW_D-1:0] divisor;
    logic            out_valid;
    logic            out_ready;
    logic [DW_N-1:0] quotient;
    logic [DW_D-1:0] remainder;
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
    logic            div_zero;
`endif

    // Producer/consumer side
    modport master (
        output in_valid, dividend, divisor, out_ready,
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
        input  div_zero,
`endif
        input  in_ready, out_valid, quotient, remainder
    );

    // Divider side
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
        output div_zero,
`endif
        output in_ready, out_valid, quotient, remainder
    );

endinterface

// File: rtl/seq_divide_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
    parameter int unsigned DW_D = 9
) (
    input  logic [DW_D:0]   prem,
    input  logic            din,
    input  logic [DW_D-1:0] divisor,
    output logic [DW_D:0]   prem_next_c,
    output logic            qbit_c
);

    logic [DW_D+1:0] shifted;
    logic [DW_D:0]   trial;

    // The kept difference is always below the divisor, so DW_D+1 bits hold it exactly
    always_comb begin
        shifted     = {prem, din};
        qbit_c      = (shifted >= (DW_D+2)'(divisor));
        trial       = shifted[DW_D:0] - (DW_D+1)'(divisor);
        prem_next_c = qbit_c ? trial : shifted[DW_D:0];
    end

endmodule

// File: rtl/seq_divide.sv
// Sequential unsigned divider: restoring shift-subtract, one quotient bit per cycle.
// Optional div_zero result flag is enabled by SEQ_DIVIDE_DZ_FLAG_EN.
module seq_divide
    import seq_divide_pkg::*;
#(
    parameter int unsigned DW_N = DIV_DW_N,
    parameter int unsigned DW_D = DIV_DW_D
) (
    input logic         clk,
    input logic         rst_n,
    seq_divide_if.slave bus
);

    localparam int unsigned CW = div_cnt_w(DW_N);
    localparam logic [CW-1:0] LAST_STEP = CW'(DW_N - 1);

    div_state_t      state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [DW_N-1:0] dvd, dvd_n;
    logic [DW_D-1:0] dvs, dvs_n;
    logic [DW_D:0]   prem, prem_n;
    logic            dz, dz_n;
    logic [DW_N-1:0] quo, quo_n;
    logic [DW_D-1:0] rem, rem_n;
    logic            in_rdy, in_rdy_n;
    logic            out_vld, out_vld_n;
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
    logic            dzf, dzf_n;
`endif

    logic [DW_D:0]   step_prem;
    logic            step_q;

    div_step #(.DW_D(DW_D)) u_step (
        .prem        (prem),
        .din         (dvd[DW_N-1]),
        .divisor     (dvs),
        .prem_next_c (step_prem),
        .qbit_c      (step_q)
    );

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            dvd     <= '0;
            dvs     <= '0;
            prem    <= '0;
            dz      <= 1'b0;
            quo     <= '0;
            rem     <= '0;
            in_rdy  <= 1'b1;
            out_vld <= 1'b0;
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
            dzf     <= 1'b0;
`endif
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            dvd     <= dvd_n;
            dvs     <= dvs_n;
            prem    <= prem_n;
            dz      <= dz_n;
            quo     <= quo_n;
            rem     <= rem_n;
            in_rdy  <= in_rdy_n;
            out_vld <= out_vld_n;
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
            dzf     <= dzf_n;
`endif
        end
    end

    // Next state, datapath updates and handshake flags
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dvd_n   = dvd;
        dvs_n   = dvs;
        prem_n  = prem;
        dz_n    = dz;
        quo_n   = quo;
        rem_n   = rem;
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
        dzf_n   = dzf;
`endif

        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    dvd_n   = bus.dividend;
                    dvs_n   = bus.divisor;
                    prem_n  = '0;
                    cnt_n   = '0;
                    dz_n    = (bus.divisor == '0);
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
                    dzf_n   = 1'b0;
`endif
                    state_n = RUN;
                end
            end
            RUN: begin
                // A zero divisor leaves after a single cycle with the saturated result
                if (dz) begin
                    quo_n   = '1;
                    rem_n   = dvd[DW_D-1:0];
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
                    dzf_n   = 1'b1;
`endif
                    state_n = DONE;
                end else begin
                    prem_n = step_prem;
                    dvd_n  = {dvd[DW_N-2:0], step_q};
                    cnt_n  = cnt + CW'(1);
                    if (cnt == LAST_STEP) begin
                        quo_n   = {dvd[DW_N-2:0], step_q};
                        rem_n   = step_prem[DW_D-1:0];
                        state_n = DONE;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        in_rdy_n  = (state_n == IDLE);
        out_vld_n = (state_n == DONE);
    end

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = out_vld;
    assign bus.quotient  = quo;
    assign bus.remainder = rem;
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
    assign bus.div_zero  = dzf;
`endif

endmodule

// File: tb/tb_seq_divide.sv
// Directed and random bench for seq_divide with a result scoreboard.
// Checks div_zero as well when SEQ_DIVIDE_DZ_FLAG_EN is defined.
module tb_seq_divide;
    import seq_divide_pkg::*;

    localparam int unsigned N = DIV_DW_N;
    localparam int unsigned D = DIV_DW_D;

    typedef struct {
        logic [N-1:0] q;
        logic [D-1:0] r;
        logic         dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seq_divide_if #(.DW_N(N), .DW_D(D)) bus ();

    seq_divide #(.DW_N(N), .DW_D(D)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present operands until accepted, push the expected result, then scramble the bus
    task automatic issue(input logic [N-1:0] a, input logic [D-1:0] b, output int acc);
        int   k;
        exp_t e;
        k = 0;
        while (!bus.in_ready && k < 100) begin
            step();
            k++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        step();
        acc = cyc;
        bus.in_valid = 1'b0;
        bus.dividend = ~a;
        bus.divisor  = ~b;
        if (b == '0) begin
            e.q  = '1;
            e.r  = a[D-1:0];
            e.dz = 1'b1;
        end else begin
            e.q  = N'(a / N'(b));
            e.r  = D'(a % N'(b));
            e.dz = 1'b0;
        end
        sb.push_back(e);
    endtask

    // Wait for a result, optionally stall it, compare against the scoreboard, then take it
    task automatic collect(input string tag, input int acc, input int hold,
                           output logic [N-1:0] q_obs, output logic [D-1:0] r_obs);
        int           k;
        exp_t         e;
        logic [N-1:0] q0;
        logic [D-1:0] r0;
        k = 0;
        while (!bus.out_valid && k < 200) begin
            step();
            k++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_lat"}, 32'(cyc - acc), (bus.divisor == ~D'(0)) ? 32'd1 : 32'(N));
        check({tag, "_sb"}, 32'(sb.size()), 32'd1);
        if (sb.size() > 0) e = sb.pop_front();
        q0 = bus.quotient;
        r0 = bus.remainder;
        for (int i = 0; i < hold; i++) begin
            step();
            check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
            check({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
            check({tag, "_hold_q"}, 32'(bus.quotient), 32'(q0));
            check({tag, "_hold_r"}, 32'(bus.remainder), 32'(r0));
        end
        check({tag, "_q"}, 32'(bus.quotient), 32'(e.q));
        check({tag, "_r"}, 32'(bus.remainder), 32'(e.r));
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
        check({tag, "_dz"}, 32'(bus.div_zero), 32'(e.dz));
`endif
        q_obs = bus.quotient;
        r_obs = bus.remainder;
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        check({tag, "_drop"}, 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int           acc, acc2, acc3, seen;
        logic [N-1:0] q, a;
        logic [D-1:0] r, b;
        int unsigned  x;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) step();
        rst_n = 1'b1;
        step();
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_q", 32'(bus.quotient), 32'd0);
        check("rst_r", 32'(bus.remainder), 32'd0);
`ifdef SEQ_DIVIDE_DZ_FLAG_EN
        check("rst_dz", 32'(bus.div_zero), 32'd0);
`endif

        // Latency is checked against the divisor the bench scrambles to ~b: ~0 means b was 0
        issue(17'd100, 9'd7, acc);       collect("d100_7", acc, 0, q, r);
        check("d100_7_qv", 32'(q), 32'd14);
        issue(17'd131071, 9'd511, acc);  collect("dmax", acc, 0, q, r);
        check("dmax_qv", 32'(q), 32'd256);
        check("dmax_rv", 32'(r), 32'd255);
        issue(17'd3, 9'd9, acc);         collect("d3_9", acc, 0, q, r);
        issue(17'd0, 9'd3, acc);         collect("d0_3", acc, 0, q, r);
        issue(17'd5, 9'd0, acc);         collect("dz5", acc, 0, q, r);
        check("dz5_qv", 32'(q), 32'h1FFFF);
        check("dz5_rv", 32'(r), 32'd5);
        issue(17'd10, 9'd2, acc);        collect("d10_2", acc, 0, q, r);
        check("d10_2_qv", 32'(q), 32'd5);

        // out_ready with no result pending must not disturb the idle block
        bus.out_ready = 1'b1;
        repeat (3) step();
        bus.out_ready = 1'b0;
        check("idle_ordy_valid", 32'(bus.out_valid), 32'd0);
        check("idle_ordy_ready", 32'(bus.in_ready), 32'd1);
        check("idle_ordy_q", 32'(bus.quotient), 32'd5);

        issue(17'd40000, 9'd123, acc);   collect("bp", acc, 5, q, r);
        issue(17'd777, 9'd5, acc);       collect("b2b1", acc, 0, q, r);
        issue(17'd65536, 9'd256, acc2);  collect("b2b2", acc2, 0, q, r);
        issue(17'd9999, 9'd99, acc3);    collect("b2b3", acc3, 0, q, r);
        check("issue_int_1", 32'(acc2 - acc), 32'd19);
        check("issue_int_2", 32'(acc3 - acc2), 32'd19);

        // Reset in the middle of a division discards it
        issue(17'd50000, 9'd77, acc);
        repeat (8) step();
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        check("mid_rst_q", 32'(bus.quotient), 32'd0);
        check("mid_rst_r", 32'(bus.remainder), 32'd0);
        sb.delete();
        step();
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (bus.out_valid) seen++;
        end
        check("mid_rst_no_emit", 32'(seen), 32'd0);
        issue(17'd1000, 9'd33, acc);     collect("d1000_33", acc, 0, q, r);
        check("d1000_33_qv", 32'(q), 32'd30);
        check("d1000_33_rv", 32'(r), 32'd10);

        // Random pairs; every other one is a multiplier product that must divide back exactly
        for (int i = 0; i < 1000; i++) begin
            b = D'($urandom_range(1, (1 << D) - 1));
            if (i % 2 == 0) begin
                x = $urandom_range(0, ((1 << N) - 1) / 32'(b));
                a = N'(x * 32'(b));
            end else begin
                x = 0;
                a = N'($urandom_range(0, (1 << N) - 1));
            end
            issue(a, b, acc);
            collect("rnd", acc, 0, q, r);
            check("rnd_recon", 32'(q) * 32'(b) + 32'(r), 32'(a));
            check("rnd_rem_lt", 32'(r < b), 32'd1);
            if (i % 2 == 0) begin
                check("rnd_prod_q", 32'(q), x);
                check("rnd_prod_r", 32'(r), 32'd0);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
